// File: rtl/cpu_x_pkg.sv
// Shared definitions for the cpu_x core: opcodes, FSM states, instruction fields, CC bits.
// Bit numbering is big-endian throughout (bit 0 = MSB).
package cpu_x_pkg;

   typedef enum logic [2:0] {FETCH, DECODE, INDIRECT, EXECUTE, HALT} state_t;

   localparam logic [6:0] OP_AI   = 7'h20;
   localparam logic [6:0] OP_LI   = 7'h22;
   localparam logic [6:0] OP_WAIT = 7'h2E;
   localparam logic [6:0] OP_AW   = 7'h30;
   localparam logic [6:0] OP_LW   = 7'h32;
   localparam logic [6:0] OP_BCR  = 7'h68;
   localparam logic [6:0] OP_BCS  = 7'h69;

   localparam int F_IND    = 0;
   localparam int F_OPC_HI = 1;
   localparam int F_OPC_LO = 7;
   localparam int F_R_HI   = 8;
   localparam int F_R_LO   = 11;
   localparam int F_X_HI   = 12;
   localparam int F_X_LO   = 14;
   localparam int F_A_HI   = 15;
   localparam int F_A_LO   = 31;

   localparam int CC_CARRY = 0;
   localparam int CC_OVFL  = 1;
   localparam int CC_POS   = 2;
   localparam int CC_NEG   = 3;

   // Immediate-form opcodes never take the indirect cycle.
   function automatic logic is_immediate(input logic [6:0] op);
      return (op == OP_LI) || (op == OP_AI) || (op == OP_WAIT);
   endfunction

endpackage

// File: rtl/cpu_x_if.sv
// Read-only word-addressed memory port of the cpu_x core.
interface cpu_x_if;
   logic [15:31] memory_address;
   logic [0:31]  memory_data_in;

   modport master (output memory_address, input memory_data_in);
   modport slave  (input memory_address, output memory_data_in);
endinterface

// File: rtl/cpu_x_alu.sv
// Combinational 32-bit add/pass unit producing the condition code nibble.
module cpu_x_alu
   import cpu_x_pkg::*;
(
   input  logic [0:31] a,
   input  logic [0:31] b,
   input  logic        add_en,
   output logic [0:31] result,
   output logic [0:3]  cc
);

   logic [0:32] sum;

   always_comb begin
      sum    = {1'b0, a} + {1'b0, b};
      result = b;
      cc     = 4'b0000;
      if (add_en) begin
         result       = sum[1:32];
         cc[CC_CARRY] = sum[0];
         cc[CC_OVFL]  = (a[0] == b[0]) && (sum[1] != a[0]);
      end
      cc[CC_POS] = !result[0] && (result != 32'h0);
      cc[CC_NEG] = result[0];
   end

endmodule

// File: rtl/cpu_x.sv
// Minimal Sigma-style core: FETCH/DECODE/[INDIRECT]/EXECUTE over a combinational-read memory.
//   state    | meaning
//   FETCH    | address = PC, latch IR, PC += 1
//   DECODE   | address = indexed EA, register EA
//   INDIRECT | address = EA, replace EA with memory word
//   EXECUTE  | address = EA, perform op
//   HALT     | address = PC, wait for reset
module cpu_x
   import cpu_x_pkg::*;
#(
   parameter logic [15:31] RESET_PC    = 17'h00000,
   parameter bit           UNIMPL_HALT = 1'b1
) (
   input  logic     clock,
   input  logic     reset,
   cpu_x_if.master  mem
);

   state_t        state, state_nxt;
   logic [15:31]  pc, ea, ea_calc, addr;
   logic [0:31]   ir;
   logic [0:3]    cc;
   logic [0:31]   regs [0:15];

   logic [6:0]    opcode;
   logic [0:3]    r_f;
   logic [0:2]    x_f;
   logic [0:31]   imm;
   logic [0:31]   alu_b, alu_result;
   logic [0:3]    alu_cc;
   logic          alu_add, reg_we, br_take;

   assign opcode  = ir[F_OPC_HI:F_OPC_LO];
   assign r_f     = ir[F_R_HI:F_R_LO];
   assign x_f     = ir[F_X_HI:F_X_LO];
   assign imm     = {{12{ir[F_X_HI]}}, ir[F_X_HI:F_A_LO]};
   assign ea_calc = ir[F_A_HI:F_A_LO] + ((x_f != 3'd0) ? regs[{1'b0, x_f}][15:31] : 17'h0);

   assign alu_add = (opcode == OP_AI) || (opcode == OP_AW);
   assign alu_b   = ((opcode == OP_LI) || (opcode == OP_AI)) ? imm : mem.memory_data_in;

   cpu_x_alu u_alu (
      .a      (regs[r_f]),
      .b      (alu_b),
      .add_en (alu_add),
      .result (alu_result),
      .cc     (alu_cc)
   );

   // Address is muxed from registered sources only; reset forces the restart vector.
   assign mem.memory_address = reset ? RESET_PC : addr;

   always_ff @(posedge clock) begin
      if (reset) state <= FETCH;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      addr      = pc;
      reg_we    = 1'b0;
      br_take   = 1'b0;
      case (state)
         FETCH: begin
            addr      = pc;
            state_nxt = DECODE;
         end
         DECODE: begin
            addr      = ea_calc;
            state_nxt = (ir[F_IND] && !is_immediate(opcode)) ? INDIRECT : EXECUTE;
         end
         INDIRECT: begin
            addr      = ea;
            state_nxt = EXECUTE;
         end
         EXECUTE: begin
            addr      = ea;
            state_nxt = FETCH;
            case (opcode)
               OP_LI, OP_AI, OP_LW, OP_AW: reg_we = 1'b1;
               OP_BCR:  br_take = ((cc & r_f) == 4'b0000);
               OP_BCS:  br_take = ((cc & r_f) != 4'b0000);
               OP_WAIT: state_nxt = HALT;
               default: if (UNIMPL_HALT) state_nxt = HALT;
            endcase
         end
         HALT: begin
            addr      = pc;
            state_nxt = HALT;
         end
         default: state_nxt = FETCH;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc <= RESET_PC;
         ea <= 17'h0;
         ir <= 32'h0;
         cc <= 4'b0000;
         for (int i = 0; i < 16; i++) regs[i] <= 32'h0;
      end else begin
         case (state)
            FETCH: begin
               ir <= mem.memory_data_in;
               pc <= pc + 17'd1;
            end
            DECODE:   ea <= ea_calc;
            INDIRECT: ea <= mem.memory_data_in[15:31];
            EXECUTE: begin
               if (reg_we) begin
                  regs[r_f] <= alu_result;
                  cc        <= alu_cc;
               end
               if (br_take) pc <= ea;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_x.sv
// Directed self-checking bench for cpu_x with a 256-word combinational memory model.
module tb_cpu_x;
   import cpu_x_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   passed = 0;
   int   total  = 0;

   logic [0:31] mem [0:255];

   cpu_x_if bus ();

   assign bus.memory_data_in = mem[bus.memory_address[24:31]];

   cpu_x #(.RESET_PC(17'h00000), .UNIMPL_HALT(1'b1)) dut (
      .clock (clock),
      .reset (reset),
      .mem   (bus)
   );

   always #5 clock = ~clock;

   task automatic begin_test();
      reset = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
   endtask

   task automatic release_reset();
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic test_reset();
      begin_test();
      mem[0] = 32'h22100005;
      mem[1] = 32'h2E000000;
      @(posedge clock); @(negedge clock);
      total++; if (bus.memory_address !== 17'h00000) $display("FAIL reset_addr: got %h need 00000", bus.memory_address); else passed++;
      release_reset();
      total++; if (bus.memory_address !== 17'h00000 || dut.state !== FETCH) $display("FAIL first_fetch: addr %h state %0d need 00000 FETCH", bus.memory_address, dut.state); else passed++;
      tick(3);
      total++; if (bus.memory_address !== 17'h00001 || dut.state !== FETCH) $display("FAIL second_fetch: addr %h state %0d need 00001 FETCH", bus.memory_address, dut.state); else passed++;
   endtask

   task automatic test_li_wait();
      begin_test();
      mem[0] = 32'h22100005;
      mem[1] = 32'h2E000000;
      release_reset();
      tick(3);
      total++; if (dut.regs[1] !== 32'h5 || dut.cc !== 4'b0010) $display("FAIL li: r1 %h cc %b need 00000005 0010", dut.regs[1], dut.cc); else passed++;
      tick(3);
      total++; if (dut.state !== HALT || bus.memory_address !== 17'h00002) $display("FAIL wait_halt: state %0d addr %h need HALT 00002", dut.state, bus.memory_address); else passed++;
      tick(10);
      total++; if (dut.state !== HALT || bus.memory_address !== 17'h00002) $display("FAIL halt_hold: state %0d addr %h need HALT 00002", dut.state, bus.memory_address); else passed++;
   endtask

   task automatic test_reset_clears();
      begin_test();
      @(posedge clock); @(negedge clock);
      total++; if (dut.regs[1] !== 32'h0 || dut.cc !== 4'b0000 || dut.ir !== 32'h0 || dut.pc !== 17'h0) $display("FAIL reset_clear: r1 %h cc %b ir %h pc %h need all zero", dut.regs[1], dut.cc, dut.ir, dut.pc); else passed++;
   endtask

   task automatic test_lw_aw();
      begin_test();
      mem[0]    = 32'h32200040;
      mem[1]    = 32'h30200040;
      mem[8'h40] = 32'hFFFFFFFE;
      release_reset();
      tick(3);
      total++; if (dut.regs[2] !== 32'hFFFFFFFE || dut.cc !== 4'b0001) $display("FAIL lw: r2 %h cc %b need fffffffe 0001", dut.regs[2], dut.cc); else passed++;
      tick(3);
      total++; if (dut.regs[2] !== 32'hFFFFFFFC || dut.cc !== 4'b1001) $display("FAIL aw: r2 %h cc %b need fffffffc 1001", dut.regs[2], dut.cc); else passed++;
      tick(4);
      total++; if (dut.state !== HALT || bus.memory_address !== 17'h00003) $display("FAIL unimpl_halt: state %0d addr %h need HALT 00003", dut.state, bus.memory_address); else passed++;
   endtask

   task automatic test_indirect();
      begin_test();
      mem[0]     = 32'hB2300041;
      mem[8'h41] = 32'h00000040;
      mem[8'h40] = 32'h12345678;
      release_reset();
      tick(1);
      total++; if (bus.memory_address !== 17'h00041 || dut.state !== DECODE) $display("FAIL ind_decode: addr %h state %0d need 00041 DECODE", bus.memory_address, dut.state); else passed++;
      tick(1);
      total++; if (bus.memory_address !== 17'h00041 || dut.state !== INDIRECT) $display("FAIL ind_cycle: addr %h state %0d need 00041 INDIRECT", bus.memory_address, dut.state); else passed++;
      tick(1);
      total++; if (bus.memory_address !== 17'h00040 || dut.state !== EXECUTE || dut.regs[3] !== 32'h0) $display("FAIL ind_exec: addr %h state %0d r3 %h need 00040 EXECUTE 0", bus.memory_address, dut.state, dut.regs[3]); else passed++;
      tick(1);
      total++; if (dut.regs[3] !== 32'h12345678 || bus.memory_address !== 17'h00001 || dut.state !== FETCH) $display("FAIL ind_result: r3 %h addr %h need 12345678 00001", dut.regs[3], bus.memory_address); else passed++;
   endtask

   task automatic test_indexed();
      begin_test();
      mem[0]     = 32'h22100010;
      mem[1]     = 32'h32420030;
      mem[8'h40] = 32'hCAFEF00D;
      release_reset();
      tick(4);
      total++; if (bus.memory_address !== 17'h00040) $display("FAIL idx_ea: addr %h need 00040", bus.memory_address); else passed++;
      tick(2);
      total++; if (dut.regs[4] !== 32'hCAFEF00D || dut.cc !== 4'b0001) $display("FAIL idx_lw: r4 %h cc %b need cafef00d 0001", dut.regs[4], dut.cc); else passed++;
   endtask

   task automatic test_arith_flags();
      begin_test();
      mem[0]     = 32'h220FFFFF;
      mem[1]     = 32'h20000001;
      mem[2]     = 32'h32600050;
      mem[3]     = 32'h20600001;
      mem[8'h50] = 32'h7FFFFFFF;
      release_reset();
      tick(3);
      total++; if (dut.regs[0] !== 32'hFFFFFFFF || dut.cc !== 4'b0001) $display("FAIL li_neg: r0 %h cc %b need ffffffff 0001", dut.regs[0], dut.cc); else passed++;
      tick(3);
      total++; if (dut.regs[0] !== 32'h0 || dut.cc !== 4'b1000) $display("FAIL ai_zero_carry: r0 %h cc %b need 00000000 1000", dut.regs[0], dut.cc); else passed++;
      tick(3);
      total++; if (dut.regs[6] !== 32'h7FFFFFFF || dut.cc !== 4'b0010) $display("FAIL lw_pos: r6 %h cc %b need 7fffffff 0010", dut.regs[6], dut.cc); else passed++;
      tick(3);
      total++; if (dut.regs[6] !== 32'h80000000 || dut.cc !== 4'b0101) $display("FAIL ai_ovfl: r6 %h cc %b need 80000000 0101", dut.regs[6], dut.cc); else passed++;
   endtask

   task automatic test_branch_loop();
      begin_test();
      mem[0] = 32'h22100000;
      mem[1] = 32'h68000001;
      release_reset();
      for (int k = 1; k <= 3; k++) begin
         tick(3);
         total++; if (bus.memory_address !== 17'h00001 || dut.state !== FETCH) $display("FAIL loop_fetch%0d: addr %h state %0d need 00001 FETCH", k, bus.memory_address, dut.state); else passed++;
      end
      tick(1);
      total++; if (dut.state !== DECODE) $display("FAIL loop_decode: state %0d need DECODE", dut.state); else passed++;
      reset = 1'b1;
      #1;
      total++; if (bus.memory_address !== 17'h00000) $display("FAIL mid_reset_addr: got %h need 00000", bus.memory_address); else passed++;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      total++; if (bus.memory_address !== 17'h00000 || dut.state !== FETCH || dut.regs[1] !== 32'h0) $display("FAIL mid_reset: addr %h state %0d r1 %h need 00000 FETCH 0", bus.memory_address, dut.state, dut.regs[1]); else passed++;
   endtask

   task automatic test_bcs(input logic [0:31] first, input logic [15:31] halt_pc);
      begin_test();
      mem[0] = first;
      mem[1] = 32'h69200003;
      mem[2] = 32'h2E000000;
      mem[3] = 32'h2E000000;
      release_reset();
      tick(10);
      total++; if (dut.state !== HALT || dut.pc !== halt_pc || bus.memory_address !== halt_pc) $display("FAIL bcs_%h: state %0d pc %h addr %h need HALT %h", first, dut.state, dut.pc, bus.memory_address, halt_pc); else passed++;
   endtask

   initial begin
      test_reset();
      test_li_wait();
      test_reset_clears();
      test_lw_aw();
      test_indirect();
      test_indexed();
      test_arith_flags();
      test_branch_loop();
      test_bcs(32'h22100000, 17'h00003);
      test_bcs(32'h22100001, 17'h00004);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
